nand_gate_test_sequencer: RTL and testbench

Self-checking sequencer for a 2-input CMOS NAND gate under test. It drives the gate's a/b inputs through the exhaustive truth table (00, 01, 10, 11) for a programmable number of passes. After a settle delay it samples the gate output f, compares it with the expected NAND value and reports mismatch count, first failing vector and pass/fail. It sits beside the NAND cell in simulation and on-chip characterisation benches, replacing hand-timed stimulus.

---
 rtl/nand_gate_test_sequencer.sv | 133 +++++++++++++
 tb/tb_nand_gate_test_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/nand_gate_test_sequencer.sv
// Exhaustive truth-table sequencer for a 2-input NAND under test: drives a/b, waits a settle
// delay, samples f and accumulates mismatch count, first failing vector and a pass flag.
module nand_gate_test_sequencer #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned PASSES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StCheck, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [3:0]  pcnt_q, pcnt_d;
  logic [7:0]  scnt_q, scnt_d;
  logic        a_q, a_d, b_q, b_d;
  logic        pass_q, pass_d;
  logic [2:0]  err_q, err_d;
  logic [1:0]  fvec_q, fvec_d;
  logic        mismatch;

  // Case inequality so an undriven or X output from the gate counts as a failure.
  assign mismatch = (f !== ~(a_q & b_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= 2'b00;
      pcnt_q  <= 4'd0;
      scnt_q  <= 8'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fvec_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      StIdle: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          state_d = StApply;
          err_d   = 3'd0;
          fvec_d  = 2'b00;
          pass_d  = 1'b0;
          vec_d   = 2'b00;
          pcnt_d  = 4'd0;
        end
      end
      StApply: begin
        state_d = StSettle;
        scnt_d  = 8'(SETTLE);
      end
      StSettle: begin
        if (scnt_q <= 8'd1) begin
          state_d = StCheck;
        end
        scnt_d = scnt_q - 8'd1;
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != 3'd7) begin
            err_d = err_q + 3'd1;
          end
          if (err_q == 3'd0) begin
            fvec_d = {a_q, b_q};
          end
        end
        // a/b are loaded on the edge entering APPLY so they hold steady until the next one.
        if (vec_q != 2'b11) begin
          vec_d      = vec_q + 2'd1;
          {a_d, b_d} = vec_q + 2'd1;
          state_d    = StApply;
        end else if (pcnt_q != 4'(PASSES - 1)) begin
          vec_d      = 2'b00;
          {a_d, b_d} = 2'b00;
          pcnt_d     = pcnt_q + 4'd1;
          state_d    = StApply;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        pass_d  = (err_q == 3'd0);
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fvec_q;

endmodule

// File: tb/tb_nand_gate_test_sequencer.sv
// Bench for nand_gate_test_sequencer: table-driven gate models plus randomized truth tables
// checked against a pass/vector-level model of the run.
module tb_nand_gate_test_sequencer;

  localparam int SETTLE = 4;
  localparam int PASSES = 2;
  localparam int VC     = SETTLE + 2;
  localparam int TOTAL  = PASSES * 4 * VC;

  logic       clk = 1'b0;
  logic       rst, start, f;
  logic       a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;

  logic       rst2, start2, f2;
  logic       a2, b2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [1:0] fv2;

  int checks = 0;
  int passed = 0;

  logic [3:0] tt;
  logic       glitch;
  int         age;
  logic [1:0] last_ab;
  logic       last_busy;

  always #5 clk = ~clk;

  nand_gate_test_sequencer #(.SETTLE(SETTLE), .PASSES(PASSES)) dut (
    .clk(clk), .rst(rst), .start(start), .f(f), .a(a), .b(b), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  nand_gate_test_sequencer #(.SETTLE(1), .PASSES(1)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .f(f2), .a(a2), .b(b2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2)
  );

  // Gate model: arbitrary truth table indexed by {a,b}, optionally pulled low early in a vector.
  always @(negedge clk) begin
    if ({a, b} != last_ab || (busy && !last_busy)) age <= 0;
    else if (age < 1000) age <= age + 1;
    last_ab   <= {a, b};
    last_busy <= busy;
  end

  always_comb begin
    f = tt[{a, b}];
    if (glitch && age < SETTLE - 1) f = 1'b0;
  end

  assign f2 = ~(a2 & b2);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: walk every pass and vector, compare the table against NAND.
  task automatic model(input logic [3:0] t, output int ep, output int ee, output int ef);
    ee = 0;
    ef = 0;
    for (int p = 0; p < PASSES; p++) begin
      for (int v = 0; v < 4; v++) begin
        int want;
        want = (v == 3) ? 0 : 1;
        if (int'(t[v]) != want) begin
          if (ee == 0) ef = v;
          if (ee < 7) ee++;
        end
      end
    end
    ep = (ee == 0) ? 1 : 0;
  endtask

  task automatic run(input string name, input logic [3:0] t, input logic g, input logic spur,
                     input int ep, input int ee, input int ef);
    int bad_k, done_at, done_n;
    tt      = t;
    glitch  = g;
    bad_k   = -1;
    done_at = -1;
    done_n  = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k <= TOTAL + 1; k++) begin
      @(negedge clk);
      start = spur && (k == 10 || k == 30 || k == TOTAL);
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (k < TOTAL) begin
        if ({a, b} != 2'((k / VC) % 4) || !busy || done) begin
          if (bad_k < 0) bad_k = k;
        end
      end else if (k == TOTAL) begin
        if (!busy && bad_k < 0) bad_k = k;
      end else if (busy || done || a || b) begin
        if (bad_k < 0) bad_k = k;
      end
    end
    start = 1'b0;
    chk({name, " trace_first_bad_cycle"}, bad_k, -1);
    chk({name, " done_edge"}, done_at, TOTAL);
    chk({name, " done_pulses"}, done_n, 1);
    chk({name, " pass"}, int'(pass), ep);
    chk({name, " err_count"}, int'(err_count), ee);
    chk({name, " fail_vec"}, int'(fail_vec), ef);
  endtask

  typedef struct {
    string      name;
    logic [3:0] t;
    logic       g;
    logic       spur;
    int         ep;
    int         ee;
    int         ef;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int ep, ee, ef, busy_seen, done_seen, d2;
    tbl[0] = '{"nand",      4'b0111, 1'b0, 1'b0, 1, 0, 0};
    tbl[1] = '{"stuck1",    4'b1111, 1'b0, 1'b0, 0, 2, 3};
    tbl[2] = '{"and",       4'b1000, 1'b0, 1'b0, 0, 7, 0};
    tbl[3] = '{"glitch",    4'b0111, 1'b1, 1'b1, 1, 0, 0};

    tt = 4'b0111; glitch = 1'b0;
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {a, b, busy, done, pass, err_count, fail_vec}, 0);
    rst = 1'b0; rst2 = 1'b0;

    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done) busy_seen++;
    end
    chk("idle_no_activity", busy_seen, 0);

    foreach (tbl[i]) run(tbl[i].name, tbl[i].t, tbl[i].g, tbl[i].spur,
                         tbl[i].ep, tbl[i].ee, tbl[i].ef);

    // Stuck-at-1 run leaves a failure; abort mid-run must clear it immediately.
    tt = 4'b1111; glitch = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4 * VC + 2 * VC + 2 - 1) @(negedge clk);
    chk("abort_in_settle_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1 chk("abort_outputs_zero", {a, b, busy, done, pass, err_count, fail_vec}, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_stays_idle", busy_seen, 0);
    run("after_abort", 4'b0111, 1'b0, 1'b0, 1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      logic [3:0] rt;
      logic       rg;
      rt = 4'($urandom_range(0, 15));
      rg = 1'($urandom_range(0, 1));
      model(rt, ep, ee, ef);
      run($sformatf("rand%0d_tt%0h", r, rt), rt, rg, 1'b0, ep, ee, ef);
    end

    // Short configuration: done after 4*(1+2) edges.
    @(negedge clk);
    start2 = 1'b1;
    d2 = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2 && d2 < 0) d2 = k;
    end
    chk("short_done_edge", d2, 12);
    chk("short_pass", int'(pass2), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
